// File: rtl/winbuf_pkg.sv
// ============================================================================
//  Module   : winbuf_pkg
//  Brief    : Shared types, default parameters and WIN legality check for
//             the streaming window line buffer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package winbuf_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int c_def_data_w = 8;
    localparam int c_def_img_w  = 64;
    localparam int c_def_img_h  = 64;
    localparam int c_def_win    = 3;
    localparam int c_win_min    = 2;
    localparam int c_win_max    = 9;

    function automatic bit win_is_legal(input int win);
        return (win >= c_win_min) && (win <= c_win_max);
    endfunction

endpackage

`default_nettype wire

// File: rtl/winbuf_line_ram.sv
// ============================================================================
//  Module   : winbuf_line_ram
//  Brief    : One image-row line memory, combinational read, synchronous write.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module winbuf_line_ram
    import winbuf_pkg::*;
#(
    parameter int DEPTH  = c_def_img_w,
    parameter int DATA_W = c_def_data_w,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/window_line_buffer.sv
// ============================================================================
//  Module   : window_line_buffer
//  Brief    : Raster-scan WINxWIN window generator over WIN-1 line memories.
//             Optional macro WINBUF_ZERO_PAD_EN: emit every pixel, zero-padded.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module window_line_buffer
    import winbuf_pkg::*;
#(
    parameter int DATA_W = c_def_data_w,
    parameter int IMG_W  = c_def_img_w,
    parameter int IMG_H  = c_def_img_h,
    parameter int WIN    = c_def_win
) (
    input  logic                                 i_clk,
    input  logic                                 in_rst,
    input  logic [DATA_W-1:0]                    i_data,
    input  logic                                 i_valid,
    input  logic                                 i_sof,
    output logic [WIN-1:0][WIN-1:0][DATA_W-1:0]  o_window,
    output logic                                 o_valid,
    output logic                                 o_eof,
    output logic [$clog2(IMG_H)-1:0]             o_row,
    output logic [$clog2(IMG_W)-1:0]             o_col,
    output logic                                 o_busy
);

    localparam int c_row_w = $clog2(IMG_H);
    localparam int c_col_w = $clog2(IMG_W);
    localparam logic [c_row_w-1:0] c_last_row = c_row_w'(IMG_H - 1);
    localparam logic [c_col_w-1:0] c_last_col = c_col_w'(IMG_W - 1);

    typedef logic [WIN-1:0][WIN-1:0][DATA_W-1:0] window_t;

    if (!win_is_legal(WIN) || (IMG_W < WIN) || (IMG_H < WIN)) begin : g_bad_cfg
        $error("window_line_buffer: illegal WIN/IMG_W/IMG_H combination");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [c_row_w-1:0] r_row;
    logic [c_row_w-1:0] w_row;
    logic [c_col_w-1:0] r_col;
    logic [c_col_w-1:0] w_col;
    logic               w_accept;
    logic               w_last;
    logic               w_emit;
    logic [DATA_W-1:0]  w_rd [WIN-1];
    window_t            r_shift;
    window_t            w_shift_next;
    window_t            w_taps;

    // A start-of-frame pixel is always taken as (0,0), in either state.
    assign w_accept = i_valid && (i_sof || (r_state == ACTIVE));
    assign w_row    = i_sof ? '0 : r_row;
    assign w_col    = i_sof ? '0 : r_col;
    assign w_last   = (w_row == c_last_row) && (w_col == c_last_col);
    assign o_busy   = (r_state == ACTIVE);

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = w_last ? IDLE : ACTIVE;
        end
    end

    always_ff @(posedge i_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_col == c_last_col) begin
                r_col <= '0;
                r_row <= w_last ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    // Memory k holds row r-1-k; each write pushes the older row down the chain.
    for (genvar k = 0; k < WIN - 1; k++) begin : g_line
        logic [DATA_W-1:0] w_wdata;
        if (k == 0) begin : g_head
            assign w_wdata = i_data;
        end else begin : g_tail
            assign w_wdata = w_rd[k-1];
        end
        winbuf_line_ram #(
            .DEPTH  (IMG_W),
            .DATA_W (DATA_W),
            .ADDR_W (c_col_w)
        ) u_ram (
            .i_clk   (i_clk),
            .i_we    (w_accept),
            .i_addr  (w_col),
            .i_wdata (w_wdata),
            .o_rdata (w_rd[k])
        );
    end

    always_comb begin
        w_shift_next = r_shift;
        for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN - 1; j++) begin
                w_shift_next[i][j] = r_shift[i][j+1];
            end
        end
        w_shift_next[WIN-1][WIN-1] = i_data;
        for (int k = 0; k < WIN - 1; k++) begin
            w_shift_next[WIN-2-k][WIN-1] = w_rd[k];
        end
    end

`ifdef WINBUF_ZERO_PAD_EN
    assign w_emit = w_accept;

    // Taps above row 0 or left of column 0 carry stale data; force them to 0.
    always_comb begin
        w_taps = w_shift_next;
        for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN; j++) begin
                if (((int'(w_row) + i) < (WIN - 1)) || ((int'(w_col) + j) < (WIN - 1))) begin
                    w_taps[i][j] = '0;
                end
            end
        end
    end
`else
    localparam logic [c_row_w-1:0] c_first_row = c_row_w'(WIN - 1);
    localparam logic [c_col_w-1:0] c_first_col = c_col_w'(WIN - 1);

    assign w_emit = w_accept && (w_row >= c_first_row) && (w_col >= c_first_col);
    assign w_taps = w_shift_next;
`endif

    always_ff @(posedge i_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_shift  <= '0;
            o_window <= '0;
            o_valid  <= 1'b0;
            o_eof    <= 1'b0;
            o_row    <= '0;
            o_col    <= '0;
        end else begin
            o_valid <= w_emit;
            o_eof   <= w_emit && w_last;
            if (w_accept) begin
                r_shift <= w_shift_next;
            end
            if (w_emit) begin
                o_window <= w_taps;
                o_row    <= w_row;
                o_col    <= w_col;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_window_line_buffer.sv
// ============================================================================
//  Module   : tb_window_line_buffer
//  Brief    : Scoreboard bench for window_line_buffer (WIN=3, 8x6 frames).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_window_line_buffer;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 6;
    localparam int WIN    = 3;
    localparam int RW     = $clog2(IMG_H);
    localparam int CW     = $clog2(IMG_W);
    localparam int NPIX   = IMG_W * IMG_H;

`ifdef WINBUF_ZERO_PAD_EN
    localparam int         EXP_STROBES  = 48;
    localparam int         FIRST_R      = 0;
    localparam int         FIRST_C      = 0;
    localparam logic [7:0] EXP_FIRST_TL = 8'h00;
    localparam logic [7:0] EXP_FIRST_BR = 8'h01;
`else
    localparam int         EXP_STROBES  = 24;
    localparam int         FIRST_R      = 2;
    localparam int         FIRST_C      = 2;
    localparam logic [7:0] EXP_FIRST_TL = 8'h01;
    localparam logic [7:0] EXP_FIRST_BR = 8'h23;
`endif
    localparam logic [7:0] EXP_LAST_TL = 8'h36;
    localparam logic [7:0] EXP_LAST_BR = 8'h58;

    typedef logic [WIN-1:0][WIN-1:0][DATA_W-1:0] win_t;
    typedef struct {
        win_t w;
        int   r;
        int   c;
        bit   eof;
    } exp_t;

    logic              i_clk = 1'b0;
    logic              in_rst;
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              i_sof;
    win_t              o_window;
    logic              o_valid;
    logic              o_eof;
    logic [RW-1:0]     o_row;
    logic [CW-1:0]     o_col;
    logic              o_busy;

    always #5 i_clk = ~i_clk;

    window_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .WIN    (WIN)
    ) dut (
        .i_clk    (i_clk),
        .in_rst   (in_rst),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_sof    (i_sof),
        .o_window (o_window),
        .o_valid  (o_valid),
        .o_eof    (o_eof),
        .o_row    (o_row),
        .o_col    (o_col),
        .o_busy   (o_busy)
    );

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   strobes  = 0;
    bit   seen_first;
    win_t cap_first;
    win_t cap_last;

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(r * 16 + c + 1);
    endfunction

    function automatic win_t model_win(input int r, input int c);
        win_t w;
        for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN; j++) begin
                int rr = r - (WIN - 1) + i;
                int cc = c - (WIN - 1) + j;
                w[i][j] = (rr < 0 || cc < 0) ? 8'h00 : pix(rr, cc);
            end
        end
        return w;
    endfunction

    function automatic bit emits(input int r, input int c);
`ifdef WINBUF_ZERO_PAD_EN
        return (r >= 0) && (c >= 0);
`else
        return (r >= WIN - 1) && (c >= WIN - 1);
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge i_clk) begin
        exp_t e;
        if (in_rst === 1'b1 && o_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_window: got strobe at row %0d col %0d, expected none", o_row, o_col);
            end else begin
                e = sb.pop_front();
                if (o_window !== e.w || o_row !== RW'(e.r) || o_col !== CW'(e.c) || o_eof !== e.eof) begin
                    failures++;
                    $display("FAIL window_r%0d_c%0d: got row=%0d col=%0d eof=%0b win=%h, expected row=%0d col=%0d eof=%0b win=%h",
                             e.r, e.c, o_row, o_col, o_eof, o_window, e.r, e.c, e.eof, e.w);
                end
                strobes++;
                if (e.r == FIRST_R && e.c == FIRST_C) begin
                    cap_first  = o_window;
                    seen_first = 1'b1;
                end
                if (e.eof) begin
                    cap_last = o_window;
                end
            end
        end
    end

    task automatic drive(input int r, input int c, input bit sof, input bit acc);
        exp_t e;
        @(posedge i_clk);
        #1;
        i_valid = 1'b1;
        i_sof   = sof;
        i_data  = pix(r, c);
        if (acc && emits(r, c)) begin
            e.w   = model_win(r, c);
            e.r   = r;
            e.c   = c;
            e.eof = (r == IMG_H - 1) && (c == IMG_W - 1);
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
            i_sof   = 1'b0;
            i_data  = 8'($urandom);
        end
    endtask

    task automatic begin_stats();
        strobes    = 0;
        seen_first = 1'b0;
        cap_first  = '0;
        cap_last   = '0;
    endtask

    // Pixels from raster index 'first' to the end of the frame, then the tail checks.
    task automatic frame(input int first, input int max_gap);
        for (int n = first; n < NPIX; n++) begin
            drive(n / IMG_W, n % IMG_W, n == 0, 1'b1);
            if (n != NPIX - 1 && max_gap > 0) begin
                idle($urandom_range(0, max_gap));
            end
        end
        @(negedge i_clk);
        check("busy_before_last", 64'(o_busy), 64'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        @(negedge i_clk);
        check("eof_last", 64'(o_eof), 64'd1);
        check("busy_after_last", 64'(o_busy), 64'd0);
        idle(2);
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_strobes"},  64'(strobes), 64'(EXP_STROBES));
        check({tag, "_first_seen"}, 64'(seen_first), 64'd1);
        check({tag, "_first_tl"}, 64'(cap_first[0][0]), 64'(EXP_FIRST_TL));
        check({tag, "_first_br"}, 64'(cap_first[WIN-1][WIN-1]), 64'(EXP_FIRST_BR));
        check({tag, "_last_tl"},  64'(cap_last[0][0]), 64'(EXP_LAST_TL));
        check({tag, "_last_br"},  64'(cap_last[WIN-1][WIN-1]), 64'(EXP_LAST_BR));
        check({tag, "_drained"},  64'(sb.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"},  64'(o_valid), 64'd0);
        check({tag, "_eof"},    64'(o_eof), 64'd0);
        check({tag, "_row"},    64'(o_row), 64'd0);
        check({tag, "_col"},    64'(o_col), 64'd0);
        check({tag, "_busy"},   64'(o_busy), 64'd0);
        check({tag, "_window"}, 64'(|o_window), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_rst  = 1'b0;
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_data  = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_outputs_zero("reset");
        @(posedge i_clk);
        #1;
        in_rst = 1'b1;

        begin_stats();
        frame(0, 0);
        end_checks("nogap");

        begin_stats();
        frame(0, 5);
        end_checks("gaps");

        // Non-SOF pixels while idle must be ignored entirely.
        begin_stats();
        for (int k = 0; k < 6; k++) begin
            drive(0, k, 1'b0, 1'b0);
            @(negedge i_clk);
            check("idle_busy", 64'(o_busy), 64'd0);
        end
        idle(2);
        check("idle_strobes", 64'(strobes), 64'd0);
        frame(0, 0);
        end_checks("after_idle");

        // Restart: SOF arrives where pixel (3,4) would have been.
        begin_stats();
        for (int n = 0; n < 3 * IMG_W + 4; n++) begin
            drive(n / IMG_W, n % IMG_W, n == 0, 1'b1);
        end
        drive(0, 0, 1'b1, 1'b1);
        @(negedge i_clk);
        #1;
        begin_stats();
        frame(1, 0);
        end_checks("restart");

        // Asynchronous reset pulse while pixel (4,5) is presented.
        begin_stats();
        for (int n = 0; n < 4 * IMG_W + 5; n++) begin
            drive(n / IMG_W, n % IMG_W, n == 0, 1'b1);
        end
        drive(4, 5, 1'b0, 1'b0);
        @(negedge i_clk);
        #1;
        in_rst = 1'b0;
        #2;
        check_outputs_zero("midreset");
        check("midreset_drained", 64'(sb.size()), 64'd0);
        i_valid = 1'b0;
        i_sof   = 1'b0;
        @(posedge i_clk);
        #1;
        in_rst = 1'b1;
        begin_stats();
        frame(0, 0);
        end_checks("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/window_line_buffer.md
# window_line_buffer

Parametrised streaming window generator for the texture-recognition front end. It accepts a raster-scan pixel stream, holds WIN-1 previous image rows in circular line memories, and emits a WIN×WIN pixel window once per accepted pixel, as soon as that window is fully inside the frame. It feeds the texture-feature stages (LBP/GLCM) with frame and position tagging, and replaces the fixed 8×9 shift-register buffer.

## Interface
- DATA_W, 8, bits per pixel
- IMG_W, 64, pixels per row; IMG_W ≥ WIN
- IMG_H, 64, rows per frame; IMG_H ≥ WIN
- WIN, 3, window side; legal range 2..9
- i_clk  in  1  clock, rising edge
- in_rst  in  1  reset: asynchronous, active-low. Clock is i_clk.
- i_data  in  DATA_W  pixel
- i_valid  in  1  pixel strobe; a pixel is accepted when i_valid=1 and the FSM accepts it (see Operation)
- i_sof  in  1  start of frame; sampled only when i_valid=1
- o_window  out  WIN×WIN×DATA_W  packed as [row][col][bit]; [0][0] is the oldest (top-left) tap; [WIN-1][WIN-1] is the newest pixel
- o_valid  out  1  one-cycle window strobe
- o_eof  out  1  asserted with o_valid on the last window of a frame
- o_row  out  clog2(IMG_H)  row of the anchor (newest) pixel
- o_col  out  clog2(IMG_W)  column of the anchor pixel
- o_busy  out  1  FSM is in ACTIVE

## Operation
- FSM states: IDLE and ACTIVE.
  - IDLE: i_valid with i_sof=1 → accept the pixel as (0,0) and go to ACTIVE. i_valid with i_sof=0 → discard the pixel; it has no effect.
  - ACTIVE: every i_valid pixel is accepted.
    - Accepting (IMG_H-1, IMG_W-1) returns the FSM to IDLE.
    - i_sof=1 in ACTIVE restarts the frame: the pixel becomes (0,0) and the FSM stays in ACTIVE.
- Column and row counters: the column counter wraps at IMG_W-1 and increments the row counter.
- Line memories: WIN-1 memories, IMG_W deep, indexed by column.
  - Memory k holds row r-1-k.
  - On each accept at column c, every memory is read combinationally at address c before it is written.
  - Memory 0 is written with i_data. Memory k is written with the old value read from memory k-1.
- Window register: on each accept, every window row shifts one column toward index 0. The new column enters at index WIN-1:
  - row WIN-1 takes i_data;
  - row WIN-2-k takes the output of memory k.
- Tap mapping: o_window[i][j] = pixel(r-(WIN-1)+i, c-(WIN-1)+j), where (r,c) is the anchor pixel.
- Emission, without padding: o_valid is asserted only for anchors with r ≥ WIN-1 and c ≥ WIN-1. This gives (IMG_H-WIN+1)·(IMG_W-WIN+1) windows per frame. All taps of an emitted window were written during the current frame, so stale memory contents never reach the output.
- o_eof is asserted only with the window anchored at (IMG_H-1, IMG_W-1).
- Memory contents are not reset.

## Timing
- Reset values: o_window=0, o_valid=0, o_eof=0, o_row=0, o_col=0, o_busy=0. FSM in IDLE, counters at 0, window register at 0.
- Latency: o_window, o_valid, o_eof, o_row and o_col are registered. They update on the edge that accepts the anchor pixel and are visible in the following cycle.
- o_window holds its value between strobes.
- There is no backpressure. A pixel may be accepted on every cycle. Gaps in i_valid stall all state.
- o_busy follows the FSM state register.
- An i_sof restart and an acceptance in the same cycle are a single event: the pixel is accepted as (0,0).
- Reset deasserted mid-frame: the block returns to IDLE and waits for the next i_sof.

## Configuration
- WINBUF_ZERO_PAD_EN defined:
  - A window is emitted for every accepted pixel, IMG_W·IMG_H per frame.
  - Any tap whose row index or column index is negative is forced to 0 at the output register.
  - o_eof rule is unchanged.
- WINBUF_ZERO_PAD_EN undefined: interior-only emission as described in Operation; no masking logic is built.

## Structure
- Package winbuf_pkg:
  - state enum: IDLE, ACTIVE;
  - default parameter constants;
  - WIN legality check function, used in an elaboration-time assertion.
- Sub-module winbuf_line_ram:
  - one IMG_W × DATA_W memory;
  - combinational read, synchronous write;
  - instantiated WIN-1 times from a generate loop.

## Test plan
Common setup: WIN=3, IMG_W=8, IMG_H=6. Each pixel value is row·16+col+1.
- Full frame, no pad:
  - Exactly 24 o_valid strobes.
  - First window has o_row=2, o_col=2, [0][0]=0x01, [2][2]=0x23.
  - Last window has o_eof=1, [2][2]=0x58, [0][0]=0x36; o_busy drops in the cycle after it.
- Random i_valid gaps of 0–5 cycles: the window sequence is identical to the gap-free run.
- i_sof reasserted at pixel (3,4): the frame restarts at (0,0). The next emitted window is at anchor (2,2) with the same values as the first-window check.
- Pixels with i_sof=0 in IDLE: no o_valid and o_busy stays 0. The following i_sof frame is correct.
- in_rst pulsed at pixel (4,5): all outputs read 0 and the FSM is in IDLE. A new full frame then produces 24 correct windows.
- WINBUF_ZERO_PAD_EN defined:
  - 48 strobes.
  - First window at (0,0): [2][2]=0x01, all other taps 0.
  - Window at (1,0): [1][2]=0x01, [2][2]=0x11, all other taps 0.
